// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares a single byte-wide synchronous RAM port between the instruction
// cache (word fetches) and the load/store buffer (byte/half/word loads and
// stores). Requests are arbitrated round-robin when both are pending. Each
// access is broken into byte transactions on the RAM port. Read data is
// assembled little-endian, and a one-cycle done pulse is returned to the
// requester.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active-low
//   rdy            global enable; low freezes every register
//   rollback       mispredict flush; aborts in-flight reads
//   ic_req/ic_addr         icache fetch request (held until ic_done)
//   ic_done/ic_data        fetch-complete pulse and fetched word
//   ls_req/ls_wr/ls_size/ls_addr/ls_wdata
//                          LSB access (size 0=byte, 1=half, 2=word)
//   ls_done/ls_rdata       LSB-complete pulse and zero-extended load data
//   mem_din/mem_dout/mem_a/mem_wr
//                          byte RAM port (read latency one cycle, mem_wr 1=write)
//   io_buffer_full         UART buffer full; stalls IO-space stores
// -----------------------------------------------------------------------------
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,

  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_done,
  output logic [31:0] ic_data,

  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,

  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,

  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IC_RD = 2'd1,
    LS_RD = 2'd2,
    LS_WR = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        last_grant, last_grant_nxt;   // 0 = IC granted last, 1 = LS
  logic        ic_done_nxt, ls_done_nxt;

  // Access context captured at grant, so a requester that drops its request
  // mid-access cannot disturb the transfer in flight.
  logic [31:0] base_r;
  logic [2:0]  len_r;
  logic [31:0] wdata_r;
  logic [31:0] rd_buf;

  logic        can_grant, grant_ic, grant_ls;
  logic        rd_active, rd_finish, io_blocked;
  logic [31:0] rd_word;
  logic [31:0] cnt_ext;
  logic [2:0]  cnt_m1;

  // Number of bytes in an LSB access; the reserved size code is treated as
  // a word.
  function automatic logic [2:0] len_of(input logic [1:0] size);
    case (size)
      2'd0:    len_of = 3'd1;
      2'd1:    len_of = 3'd2;
      default: len_of = 3'd4;
    endcase
  endfunction

  // Select byte idx of a 32-bit word (little-endian).
  function automatic logic [7:0] byte_of(input logic [31:0] word,
                                         input logic [2:0]  idx);
    case (idx[1:0])
      2'd0:    byte_of = word[7:0];
      2'd1:    byte_of = word[15:8];
      2'd2:    byte_of = word[23:16];
      default: byte_of = word[31:24];
    endcase
  endfunction

  assign cnt_ext = {29'd0, cnt};
  assign cnt_m1  = cnt - 3'd1;

  // ---------------------------------------------------------------------------
  // Arbitration: only from IDLE, never in a cycle that carries a done pulse,
  // and never while a flush is in progress. On a tie the side that did not
  // win last time goes first.
  // ---------------------------------------------------------------------------
  assign can_grant = (state == IDLE) && !ic_done && !ls_done && !rollback;
  assign grant_ic  = can_grant && ic_req && (!ls_req || last_grant);
  assign grant_ls  = can_grant && ls_req && !grant_ic;

  assign rd_active  = (state == IC_RD) || (state == LS_RD);
  // Final read cycle: all bytes issued, last byte arriving on mem_din now.
  assign rd_finish  = rd_active && (cnt == len_r);
  // Stores into IO space (addr[17:16] == 2'b11) wait for UART buffer space.
  assign io_blocked = (state == LS_WR) && (base_r[17:16] == 2'b11) &&
                      io_buffer_full;

  // Read word with the byte now arriving on mem_din merged in. The byte on
  // mem_din belongs to the address issued one cycle earlier, i.e. index cnt-1.
  always_comb begin
    rd_word = rd_buf;
    if (cnt != 3'd0) begin
      rd_word[{cnt_m1[1:0], 3'b000} +: 8] = mem_din;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      last_grant <= 1'b1;
      ic_done    <= 1'b0;
      ls_done    <= 1'b0;
    end else if (rdy) begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
      ic_done    <= ic_done_nxt;
      ls_done    <= ls_done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    ic_done_nxt    = 1'b0;
    ls_done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_ic) begin
          state_nxt      = IC_RD;
          cnt_nxt        = 3'd0;
          last_grant_nxt = 1'b0;
        end else if (grant_ls) begin
          state_nxt      = ls_wr ? LS_WR : LS_RD;
          cnt_nxt        = 3'd0;
          last_grant_nxt = 1'b1;
        end
      end
      IC_RD, LS_RD: begin
        if (rollback) begin
          // Speculative read squashed: drop partial data, no done pulse.
          state_nxt = IDLE;
          cnt_nxt   = 3'd0;
        end else if (cnt == len_r) begin
          state_nxt   = IDLE;
          cnt_nxt     = 3'd0;
          ic_done_nxt = (state == IC_RD);
          ls_done_nxt = (state == LS_RD);
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      LS_WR: begin
        // Stores are already committed, so rollback does not affect them.
        if (!io_blocked) begin
          if (cnt == len_r - 3'd1) begin
            state_nxt   = IDLE;
            cnt_nxt     = 3'd0;
            ls_done_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // RAM port outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_a    = 32'd0;
    mem_dout = 8'd0;
    mem_wr   = 1'b0;
    case (state)
      IC_RD, LS_RD: begin
        if (rdy) begin
          if (cnt < len_r) begin
            mem_a = base_r + cnt_ext;
          end
        end else if (cnt != 3'd0) begin
          // While frozen, re-present the address whose byte is still
          // awaited, so mem_din carries it again once rdy returns.
          mem_a = base_r + cnt_ext - 32'd1;
        end
      end
      LS_WR: begin
        mem_a    = base_r + cnt_ext;
        mem_dout = byte_of(wdata_r, cnt);
        // Gated by rdy so a frozen cycle does not repeat a write into IO.
        mem_wr   = rdy && !io_blocked;
      end
      default: begin
        mem_a    = 32'd0;
        mem_dout = 8'd0;
        mem_wr   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Access context and read assembly buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (grant_ic) begin
        base_r <= ic_addr;
        len_r  <= 3'd4;
        rd_buf <= 32'd0;
      end else if (grant_ls) begin
        base_r  <= ls_addr;
        len_r   <= len_of(ls_size);
        wdata_r <= ls_wdata;
        rd_buf  <= 32'd0;   // upper bytes of short loads stay zero
      end else if (rd_active && !rollback && (cnt != 3'd0)) begin
        rd_buf <= rd_word;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Returned read data; holds until the next completion for that requester
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ic_data  <= 32'd0;
      ls_rdata <= 32'd0;
    end else if (rdy && rd_finish && !rollback) begin
      if (state == IC_RD) begin
        ic_data <= rd_word;
      end else begin
        ls_rdata <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_done;
  logic [31:0] ic_data;
  logic        ls_req, ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc_now = 0;

  logic [7:0] ram [0:262143];

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // Byte RAM with one-cycle read latency; 18 address bits are decoded.
  always @(posedge clk) begin
    mem_din <= ram[mem_a[17:0]];
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
  end

  typedef struct {
    bit          is_ic;
    bit          wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_done;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_now++;
  endtask

  task automatic clear_inputs();
    rdy = 1'b1; rollback = 1'b0;
    ic_req = 1'b0; ic_addr = 32'd0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
    io_buffer_full = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_done(input bit for_ic, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (for_ic ? ic_done : ls_done) begin
        at = cyc_now;
        break;
      end
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    int got;
    n = v.is_ic ? 4 : (v.size == 2'd0 ? 1 : (v.size == 2'd1 ? 2 : 4));
    got = -1;
    cyc_now = 0;
    if (v.is_ic) begin
      ic_req = 1'b1; ic_addr = v.addr;
    end else begin
      ls_req = 1'b1; ls_wr = v.wr; ls_size = v.size; ls_addr = v.addr; ls_wdata = v.wdata;
    end
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c <= n) begin
        chk($sformatf("v%0d_c%0d_mem_a", idx, c), mem_a, v.addr + 32'(c - 1));
        chk($sformatf("v%0d_c%0d_mem_wr", idx, c), {31'd0, mem_wr}, {31'd0, v.wr});
        if (v.wr)
          chk($sformatf("v%0d_c%0d_mem_dout", idx, c), {24'd0, mem_dout},
              {24'd0, v.wdata[8*(c-1) +: 8]});
      end
      if (v.is_ic ? ic_done : ls_done) begin
        got = c;
        break;
      end
    end
    chk($sformatf("v%0d_done_cycle", idx), got, v.exp_done);
    if (!v.wr && got >= 0)
      chk($sformatf("v%0d_data", idx), v.is_ic ? ic_data : ls_rdata, v.exp_data);
    ic_req = 1'b0;
    ls_req = 1'b0;
    tick();
  endtask

  vec_t vecs [10];

  initial begin
    int at;
    int seen;

    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram[18'h100] = 8'h11; ram[18'h101] = 8'h22; ram[18'h102] = 8'h33; ram[18'h103] = 8'h44;
    ram[18'h200] = 8'hA1; ram[18'h201] = 8'hB2; ram[18'h202] = 8'hC3; ram[18'h203] = 8'hD4;
    ram[18'h010] = 8'h80;
    ram[18'h040] = 8'h9A; ram[18'h041] = 8'hBC; ram[18'h042] = 8'hDE; ram[18'h043] = 8'hF0;
    ram[18'h3FFFE] = 8'h5A; ram[18'h3FFFF] = 8'h6B; ram[18'h000] = 8'h01; ram[18'h001] = 8'h02;

    //          is_ic wr size addr          wdata         exp_data      done
    vecs[0] = '{1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0,        32'h4433_2211, 6};
    vecs[1] = '{1'b0, 1'b0, 2'd2, 32'h0000_0200, 32'h0,        32'hD4C3_B2A1, 6};
    vecs[2] = '{1'b0, 1'b0, 2'd1, 32'h0000_0202, 32'h0,        32'h0000_D4C3, 4};
    vecs[3] = '{1'b0, 1'b0, 2'd0, 32'h0000_0203, 32'h0,        32'h0000_00D4, 3};
    vecs[4] = '{1'b0, 1'b1, 2'd2, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0,        5};
    vecs[5] = '{1'b0, 1'b0, 2'd2, 32'h0000_0300, 32'h0,        32'hDEAD_BEEF, 6};
    vecs[6] = '{1'b0, 1'b1, 2'd0, 32'h0000_0305, 32'h1234_5678, 32'h0,        2};
    vecs[7] = '{1'b0, 1'b0, 2'd1, 32'h0000_0304, 32'h0,        32'h0000_7800, 4};
    vecs[8] = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,        32'h0201_6B5A, 6};
    vecs[9] = '{1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0000_BEEF, 32'h0,        3};

    // Reset state
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_ic_done", {31'd0, ic_done}, 32'd0);
    chk("rst_ls_done", {31'd0, ls_done}, 32'd0);
    chk("rst_ic_data", ic_data, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    rst = 1'b1;
    tick();
    chk("idle_mem_a", mem_a, 32'd0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);
    chk("ic_data_hold", ic_data, 32'h0201_6B5A);
    chk("wrap_store_b0", {24'd0, ram[18'h3FFFF]}, 32'h0000_00EF);
    chk("wrap_store_b1", {24'd0, ram[18'h00000]}, 32'h0000_00BE);

    // Round-robin: IC wins first tie, LS next, then IC again
    do_reset();
    cyc_now = 0;
    ic_req = 1'b1; ic_addr = 32'h100;
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h200;
    tick();
    chk("rr_first_ic_a", mem_a, 32'h100);
    wait_done(1'b1, 12, at);
    chk("rr_ic_done_cyc", at, 6);
    ic_req = 1'b0;
    tick();
    tick();
    chk("rr_ls_a", mem_a, 32'h200);
    wait_done(1'b0, 12, at);
    chk("rr_ls_done_cyc", at, 13);
    chk("rr_ls_rdata", ls_rdata, 32'hD4C3_B2A1);
    ic_req = 1'b1;
    tick();
    tick();
    chk("rr_tie_ic_a", mem_a, 32'h100);

    // Rollback in IDLE blocks that cycle's grant
    do_reset();
    ic_req = 1'b1; ic_addr = 32'h100; rollback = 1'b1;
    tick();
    rollback = 1'b0;
    chk("rbidle_no_grant", mem_a, 32'd0);
    tick();
    chk("rbidle_grant_next", mem_a, 32'h100);

    // IO store stalled by full buffer
    do_reset();
    cyc_now = 0;
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd1; ls_addr = 32'h30000; ls_wdata = 32'h0000_ABCD;
    io_buffer_full = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk($sformatf("io_c%0d_wr_low", c), {31'd0, mem_wr}, 32'd0);
    end
    tick();
    io_buffer_full = 1'b0;
    #1;
    chk("io_c4_wr", {31'd0, mem_wr}, 32'd1);
    chk("io_c4_a", mem_a, 32'h30000);
    chk("io_c4_dout", {24'd0, mem_dout}, 32'hCD);
    tick();
    chk("io_c5_wr", {31'd0, mem_wr}, 32'd1);
    chk("io_c5_a", mem_a, 32'h30001);
    chk("io_c5_dout", {24'd0, mem_dout}, 32'hAB);
    tick();
    chk("io_c6_done", {31'd0, ls_done}, 32'd1);
    ls_req = 1'b0;
    chk("io_ram", {16'd0, ram[18'h30001], ram[18'h30000]}, 32'h0000_ABCD);

    // Rollback mid IC read, then a fresh fetch
    do_reset();
    cyc_now = 0;
    ic_req = 1'b1; ic_addr = 32'h100;
    tick(); tick(); tick();
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    chk("rbic_mem_a", mem_a, 32'd0);
    chk("rbic_no_done", {31'd0, ic_done}, 32'd0);
    ic_addr = 32'h40;
    tick();
    chk("rbic_new_a", mem_a, 32'h40);
    wait_done(1'b1, 12, at);
    chk("rbic_done_cyc", at, 10);
    chk("rbic_data", ic_data, 32'hF0DE_BC9A);
    ic_req = 1'b0;

    // Rollback during a store is ignored
    do_reset();
    cyc_now = 0;
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h400; ls_wdata = 32'h1122_3344;
    tick(); tick();
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    wait_done(1'b0, 10, at);
    chk("rbst_done_cyc", at, 5);
    ls_req = 1'b0;
    tick();
    chk("rbst_ram", {ram[18'h403], ram[18'h402], ram[18'h401], ram[18'h400]}, 32'h1122_3344);

    // Reset mid store stops further bytes at once
    do_reset();
    ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h500; ls_wdata = 32'hCAFE_BABE;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rstwr_mem_wr", {31'd0, mem_wr}, 32'd0);
    ls_req = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick();
    chk("rstwr_b0", {24'd0, ram[18'h500]}, 32'hBE);
    chk("rstwr_b1", {24'd0, ram[18'h501]}, 32'h00);

    // Reset mid LS read, then a byte load
    do_reset();
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h200;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rstrd_mem_a", mem_a, 32'd0);
    chk("rstrd_ls_done", {31'd0, ls_done}, 32'd0);
    ls_req = 1'b0;
    tick(); tick();
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ls_done) seen++;
    end
    chk("rstrd_no_done", seen, 0);
    cyc_now = 0;
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h10;
    wait_done(1'b0, 8, at);
    chk("lb_done_cyc", at, 3);
    chk("lb_rdata", ls_rdata, 32'h0000_0080);
    ls_req = 1'b0;

    // rdy low for one cycle stretches a byte load by one cycle
    do_reset();
    cyc_now = 0;
    ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h10;
    tick();
    chk("stall_c1_a", mem_a, 32'h10);
    tick();
    rdy = 1'b0;
    tick();
    rdy = 1'b1;
    wait_done(1'b0, 6, at);
    chk("stall_done_cyc", at, 4);
    chk("stall_rdata", ls_rdata, 32'h0000_0080);
    ls_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
